seq_pattern_ctrl: RTL and testbench
===================================

# seq_pattern_ctrl

Programmable serial pattern-detection controller. It configures a Mealy detector (pattern, length, overlap mode) and arms it for a bounded observation window. It counts matches in that window and reports completion. It sits between a register/host interface and a 1-bit serial input stream. Reset configuration is the overlapping `1001` detector.

## Interface
Parameters:
- `WIN_W`, default 8: width of the window-length input.
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `cfg_we` in 1: configuration write strobe.
- `cfg_pattern` in 8: pattern. `pattern[len-1]` is the first received bit; `pattern[0]` is the completing bit.
- `cfg_len` in 4: pattern length; legal range 1..8.
- `cfg_overlap` in 1: 1 = overlapping matches, 0 = non-overlapping.
- `win_len` in WIN_W: number of valid bits per window; 0 = unbounded (window ends only on `stop`).
- `start` in 1: arm request.
- `stop` in 1: early window termination.
- `ip` in 1: serial data bit.
- `ip_valid` in 1: qualifies `ip`.
- `seq_det` out 1: combinational Mealy match flag.
- `busy` out 1: high while ARMED.
- `done` out 1: one-cycle pulse at window end.
- `match_cnt` out CNT_W: matches counted in the current or last window.
- `cfg_err` out 1: one-cycle pulse when a configuration write is rejected.

## Operation
States:
- IDLE: accepts `cfg_we` and `start`.
- ARMED: detection is active.
- DONE: lasts one cycle, then returns to IDLE.

Transitions:
- IDLE→ARMED when `start`=1. On that edge, clear `match_cnt`, history, fill and bit counter.
- ARMED→DONE when `stop`=1, or when the valid bit consumed this cycle is bit number `win_len` (`win_len`≠0).
- DONE→IDLE unconditionally.

Configuration writes:
- In IDLE with `cfg_len` in 1..8: latch pattern, length and overlap.
- `cfg_len`=0 or >8: config unchanged, `cfg_err` pulses.
- `cfg_we` in ARMED or DONE: ignored, `cfg_err` pulses.
- `cfg_we` and `start` in the same IDLE cycle: both take effect, and the window uses the new config.

Detection (ARMED only, and only on a cycle with `ip_valid`=1):
- `w = {hist[6:0], ip}`.
- `match` = (low `len` bits of `w` == low `len` bits of pattern) AND (`fill` ≥ `len`−1).
- `seq_det` = `busy` & `ip_valid` & `match`.
- At the edge:
  - `hist <= w[6:0]`.
  - `fill` increments, saturating at 7.
  - If `match` and non-overlap mode, `fill <= 0`.
  - If `match`, `match_cnt` increments.
- Cycles with `ip_valid`=0 change nothing.

General rules:
- Valid bits arriving in the same cycle as `stop` are consumed and counted.
- `match_cnt` holds its value through DONE and IDLE until the next `start`.
- `start` while ARMED or DONE is ignored.
- `stop` in IDLE is ignored.

## Timing
Reset values:
- State IDLE.
- `busy`=0, `done`=0, `cfg_err`=0, `match_cnt`=0, `seq_det`=0.
- Pattern 8'h09, `len`=4, overlap=1.
- `hist`=0, `fill`=0.

Cycle relationships:
- `busy` rises the cycle after `start` is sampled. The first bit can be consumed in that cycle.
- `seq_det` is valid in the same cycle as the completing `ip`. There is no registered latency.
- `match_cnt` reflects a match one cycle after the corresponding `seq_det`.
- `done` is asserted the cycle after the window-ending bit or `stop`, with `busy`=0 in that cycle.
- `cfg_err` is asserted the cycle after the offending `cfg_we`.
- `rst` mid-window returns to IDLE with reset values. The configuration also reverts to the reset values, and no `done` is produced.
- The bit counter is WIN_W bits wide. With `win_len`=0 it wraps freely and never ends the window.

## Configuration
Macro: `SEQ_CTRL_SAT_EN`.
- Defined: `match_cnt` saturates at 2^CNT_W−1.
- Undefined: `match_cnt` wraps modulo 2^CNT_W.

## Test plan
- Defaults, `start`, then `win_len`=7 valid bits 1,0,0,1,0,0,1. Expected:
  - `seq_det` high on bits 4 and 7.
  - `done` the cycle after bit 7.
  - `match_cnt`=2.
- Same stream with `cfg_overlap`=0 (pattern 8'h09, `len`=4). Expected: `seq_det` only on bit 4, `match_cnt`=1.
- Pattern 8'h01, `len`=1, `win_len`=0, with `ip_valid` gaps. Expected:
  - One count per valid 1.
  - `ip` values during invalid cycles are ignored.
  - `stop` ends the window and still counts a valid 1 present in the stop cycle.
- `cfg_we` with `cfg_len`=9 in IDLE, then `cfg_we` while ARMED. Expected: `cfg_err` pulses twice and the configuration is unchanged.
- `CNT_W`=2, 5 matches in one window. Expected:
  - `match_cnt`=3 with `SEQ_CTRL_SAT_EN` defined.
  - `match_cnt`=1 with it undefined.
- `rst` asserted mid-window after 1 match. Expected:
  - Next cycle: `busy`=0 and `match_cnt`=0.
  - No `done` pulse.
  - Configuration back to 8'h09 / 4 / overlap.

Source files
------------

// File: rtl/seq_pattern_ctrl_if.sv
// seq_pattern_ctrl_if: host/stream bundle for seq_pattern_ctrl.
// Carries the configuration write port, window control, serial input and
// the detector's status outputs. clk and rst stay outside the bundle.
interface seq_pattern_ctrl_if #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
);

  // configuration write port
  logic             cfg_we;
  logic [7:0]       cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;

  // window control
  logic [WIN_W-1:0] win_len;
  logic             start;
  logic             stop;

  // serial stream
  logic             ip;
  logic             ip_valid;

  // status
  logic             seq_det;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;

  // host / stimulus side
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    output win_len, start, stop, ip, ip_valid,
    input  seq_det, busy, done, match_cnt, cfg_err
  );

  // detector side
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    input  win_len, start, stop, ip, ip_valid,
    output seq_det, busy, done, match_cnt, cfg_err
  );

endinterface

// File: rtl/seq_pattern_ctrl.sv
// seq_pattern_ctrl: programmable Mealy serial pattern detector with a bounded
// observation window and match counter.
//
// Optional feature macro: SEQ_CTRL_SAT_EN
//   defined   -> match_cnt saturates at all-ones
//   undefined -> match_cnt wraps modulo 2^CNT_W
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepts configuration writes and start; counter holds
// ARMED | detection active, valid bits consumed and counted
// DONE  | one-cycle window-end marker, then back to IDLE
module seq_pattern_ctrl #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  seq_pattern_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] RST_PATTERN = 8'h09;
  localparam logic [3:0] RST_LEN     = 4'd4;
  localparam logic       RST_OVL     = 1'b1;

  state_t           state_q, state_d;

  logic [7:0]       pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [6:0]       hist_q, hist_d;
  logic [2:0]       fill_q, fill_d;
  logic [WIN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_err_q, cfg_err_d;

  logic             in_idle;
  logic             in_armed;
  logic             consume;
  logic [7:0]       w;
  logic [7:0]       len_mask;
  logic             pat_hit;
  logic             fill_ok;
  logic             match;
  logic [WIN_W-1:0] bit_nxt;
  logic             win_hit;
  logic             cfg_ok;
  logic [CNT_W-1:0] cnt_inc;

  // Detector datapath: window of the last len bits including the current one.
  always_comb begin
    in_idle  = (state_q == ST_IDLE);
    in_armed = (state_q == ST_ARMED);
    consume  = in_armed & bus.ip_valid;
    w        = {hist_q, bus.ip};
    // len_q is only ever loaded with 1..8, so the shift stays in 0..7
    len_mask = 8'hFF >> (4'd8 - len_q);
    pat_hit  = ((w ^ pat_q) & len_mask) == 8'h00;
    // enough earlier bits in the history to form a full pattern
    fill_ok  = ({1'b0, fill_q} >= (len_q - 4'd1));
    match    = pat_hit & fill_ok;
    bit_nxt  = bit_cnt_q + WIN_W'(1);
    win_hit  = (bus.win_len != '0) && (bit_nxt == bus.win_len);
    cfg_ok   = (bus.cfg_len != 4'd0) && (bus.cfg_len <= 4'd8);
`ifdef SEQ_CTRL_SAT_EN
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`else
    cnt_inc  = cnt_q + CNT_W'(1);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start arms, stop or the last window bit ends the window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (bus.stop || (consume && win_hit)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: status from state, seq_det straight from the live bit.
  always_comb begin
    bus.busy      = in_armed;
    bus.done      = (state_q == ST_DONE);
    bus.seq_det   = consume & match;
    bus.match_cnt = cnt_q;
    bus.cfg_err   = cfg_err_q;
  end

  // Configuration, history, fill, bit counter and match counter updates.
  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;

    // writes are only legal in IDLE with a length the detector can hold
    cfg_err_d = bus.cfg_we & (~in_idle | ~cfg_ok);

    if (in_idle && bus.cfg_we && cfg_ok) begin
      pat_d = bus.cfg_pattern;
      len_d = bus.cfg_len;
      ovl_d = bus.cfg_overlap;
    end

    if (in_idle && bus.start) begin
      hist_d    = 7'd0;
      fill_d    = 3'd0;
      bit_cnt_d = '0;
      cnt_d     = '0;
    end

    if (consume) begin
      hist_d    = w[6:0];
      fill_d    = (fill_q == 3'd7) ? 3'd7 : fill_q + 3'd1;
      bit_cnt_d = bit_nxt;
      if (match) begin
        cnt_d = cnt_inc;
        // non-overlap: bits of this match may not start the next one
        if (!ovl_q) begin
          fill_d = 3'd0;
        end
      end
    end
  end

  // Datapath registers; reset restores the overlapping 1001 detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= RST_PATTERN;
      len_q     <= RST_LEN;
      ovl_q     <= RST_OVL;
      hist_q    <= 7'd0;
      fill_q    <= 3'd0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// tb_seq_pattern_ctrl: scoreboard bench for seq_pattern_ctrl.
// Two instances share all inputs: an 8-bit counter one and a 2-bit counter
// one used to observe wrap/saturation behaviour.
module tb_seq_pattern_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_pattern_ctrl_if #(.WIN_W(8), .CNT_W(8)) bus_a ();
  seq_pattern_ctrl_if #(.WIN_W(8), .CNT_W(2)) bus_b ();

  assign bus_b.cfg_we      = bus_a.cfg_we;
  assign bus_b.cfg_pattern = bus_a.cfg_pattern;
  assign bus_b.cfg_len     = bus_a.cfg_len;
  assign bus_b.cfg_overlap = bus_a.cfg_overlap;
  assign bus_b.win_len     = bus_a.win_len;
  assign bus_b.start       = bus_a.start;
  assign bus_b.stop        = bus_a.stop;
  assign bus_b.ip          = bus_a.ip;
  assign bus_b.ip_valid    = bus_a.ip_valid;

  seq_pattern_ctrl #(.WIN_W(8), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_pattern_ctrl #(.WIN_W(8), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic       det;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt_small;
  } exp_t;

  exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int         m_st;     // 0 idle, 1 armed, 2 done
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_hist[$];
  int         m_cnt;
  logic [7:0] m_nbits;
  bit         m_err;
  logic [7:0] win;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    int sz;
    sz = m_hist.size();
    if (sz < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (m_hist[sz-1-i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [1:0] small_exp(input int c);
`ifdef SEQ_CTRL_SAT_EN
    return (c > 3) ? 2'd3 : c[1:0];
`else
    return c[1:0];
`endif
  endfunction

  task automatic model_reset();
    m_st    = 0;
    m_pat   = 8'h09;
    m_len   = 4;
    m_ovl   = 1'b1;
    m_hist.delete();
    m_cnt   = 0;
    m_nbits = 8'd0;
    m_err   = 1'b0;
  endtask

  task automatic set_win(input logic [7:0] wl);
    win           = wl;
    bus_a.win_len = wl;
  endtask

  // One clock cycle: drive inputs, predict, compare at the falling edge.
  task automatic step(input bit st, input bit we, input logic [7:0] p, input logic [3:0] l,
                      input bit o, input bit b, input bit v, input bit sp);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = 1'b0;
    bus_a.start       = st;
    bus_a.cfg_we      = we;
    bus_a.cfg_pattern = p;
    bus_a.cfg_len     = l;
    bus_a.cfg_overlap = o;
    bus_a.ip          = b;
    bus_a.ip_valid    = v;
    bus_a.stop        = sp;

    e.busy      = (m_st == 1);
    e.done      = (m_st == 2);
    e.err       = m_err;
    e.cnt       = m_cnt[7:0];
    e.cnt_small = small_exp(m_cnt);
    e.det       = 1'b0;
    if (m_st == 1 && v) begin
      m_hist.push_back(b);
      e.det = model_hit();
    end
    sb_q.push_back(e);

    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("seq_det", bus_a.seq_det, e.det);
      check_eq("busy", bus_a.busy, e.busy);
      check_eq("done", bus_a.done, e.done);
      check_eq("cfg_err", bus_a.cfg_err, e.err);
      check_eq("match_cnt", bus_a.match_cnt, e.cnt);
      check_eq("match_cnt_small", bus_b.match_cnt, e.cnt_small);
    end

    m_err = we && (m_st != 0 || l == 4'd0 || l > 4'd8);
    case (m_st)
      0: begin
        if (we && l >= 4'd1 && l <= 4'd8) begin
          m_pat = p;
          m_len = int'(l);
          m_ovl = o;
        end
        if (st) begin
          m_st    = 1;
          m_hist.delete();
          m_cnt   = 0;
          m_nbits = 8'd0;
        end
      end
      1: begin
        if (v) begin
          m_nbits = m_nbits + 8'd1;
          if (e.det) begin
            m_cnt++;
            if (!m_ovl) m_hist.delete();
          end
        end
        if (sp || (v && win != 8'd0 && m_nbits == win)) m_st = 2;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input bit b);
    step(0, 0, 8'h00, 4'd4, 1'b1, b, 1'b1, 1'b0);
  endtask

  task automatic send_stream_1001001();
    bit s[7];
    s = '{1, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) send(s[i]);
  endtask

  // Reset asserted for one edge; the following step checks the cycle after.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    bus_a.start    = 1'b0;
    bus_a.cfg_we   = 1'b0;
    bus_a.ip_valid = 1'b0;
    bus_a.stop     = 1'b0;
    bus_a.ip       = 1'b0;
    model_reset();
  endtask

  initial begin
    rst               = 1'b1;
    bus_a.cfg_we      = 1'b0;
    bus_a.cfg_pattern = 8'h00;
    bus_a.cfg_len     = 4'd4;
    bus_a.cfg_overlap = 1'b1;
    bus_a.start       = 1'b0;
    bus_a.stop        = 1'b0;
    bus_a.ip          = 1'b0;
    bus_a.ip_valid    = 1'b0;
    set_win(8'd0);
    model_reset();

    // reset values, then default 1001 overlapping detector over 7 bits
    do_reset();
    idle(2);
    check_eq("rst_busy", bus_a.busy, 1'b0);
    check_eq("rst_cnt", bus_a.match_cnt, 8'd0);
    set_win(8'd7);
    step(1, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    send_stream_1001001();
    idle(3);
    check_eq("t1_cnt", bus_a.match_cnt, 8'd2);

    // non-overlap written in the same cycle as start
    step(1, 1, 8'h09, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    send_stream_1001001();
    idle(3);
    check_eq("t2_cnt", bus_a.match_cnt, 8'd1);

    // single-bit pattern, unbounded window with gaps, stop with a valid 1
    set_win(8'd0);
    step(0, 1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 0, 8'h00, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step(0, 0, 8'h00, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    step(0, 0, 8'h00, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step(0, 0, 8'h00, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 8'h00, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step(0, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    step(0, 0, 8'h00, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    check_eq("t3_cnt", bus_a.match_cnt, 8'd4);

    // rejected writes: len 9 and len 0 in IDLE, any write while ARMED
    do_reset();
    idle(1);
    step(0, 1, 8'h01, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 1, 8'h01, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    set_win(8'd7);
    step(1, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1, 8'h01, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    send(0); send(0); send(1); send(0); send(0); send(1);
    idle(3);
    check_eq("t4_cnt", bus_a.match_cnt, 8'd2);

    // five matches in one window: 2-bit counter wraps or saturates
    set_win(8'd5);
    step(0, 1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(1);
    idle(2);
    check_eq("t5_cnt", bus_a.match_cnt, 8'd5);
`ifdef SEQ_CTRL_SAT_EN
    check_eq("t5_small", bus_b.match_cnt, 2'd3);
`else
    check_eq("t5_small", bus_b.match_cnt, 2'd1);
`endif

    // reset mid-window after one match; config must revert to 09/4/overlap
    set_win(8'd0);
    step(0, 1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    send(0); send(1); send(0);
    check_eq("t6_pre_cnt", bus_a.match_cnt, 8'd1);
    do_reset();
    idle(3);
    set_win(8'd7);
    step(1, 0, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    send_stream_1001001();
    idle(3);
    check_eq("t6_cnt", bus_a.match_cnt, 8'd2);

    // random configurations and streams against the model
    set_win(8'd0);
    for (int r = 0; r < 4; r++) begin
      step(1, 1, 8'($urandom_range(0, 255)), 4'($urandom_range(1, 8)),
           1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 48; i++) begin
        step(0, 0, 8'h00, 4'd4, 1'b1, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0), 1'b0);
      end
      step(0, 0, 8'h00, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
